spi_reg_bank: RTL
=================

SPI_REG_BANK -- requirements
Module: spi_reg_bank

Interface
REQ-001 Parameter NUM_REGS, default 4: number of writable registers, 1..16.
REQ-002 Parameter DATA_W, default 8: register width in bits, 1..32.
REQ-003 Parameter CMD_BITS, default 2: index field width; SHALL satisfy 2**CMD_BITS >= NUM_REGS.
REQ-004 Parameter RESET_VAL, default 0: reset value of every register, DATA_W bits.
REQ-005 clk  in  1  sole clock; all state SHALL change only on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 i_sclk  in  1  SPI clock, asynchronous to clk, mode 0.
REQ-008 i_mosi  in  1  SPI data, MSB first.
REQ-009 i_ss_n  in  1  SPI select, active low.
REQ-010 i_load  in  1  commit strobe, e.g. a vsync pulse; used only when the macro in REQ-030 is defined.
REQ-011 o_regs  out  NUM_REGS*DATA_W  live registers; register k occupies bits [k*DATA_W +: DATA_W].
REQ-012 o_wr_strobe  out  1  one-clk pulse when a frame completes with a valid index.
REQ-013 o_wr_index  out  CMD_BITS  index of the last completed frame, valid while o_wr_strobe is high.
REQ-014 o_err  out  1  one-clk pulse when a frame completes with index >= NUM_REGS.
REQ-015 o_busy  out  1  high while the FSM is in CMD or DATA.

Function
REQ-016 i_sclk, i_mosi and i_ss_n SHALL each pass through a 2-flop synchronizer; i_sclk rising edges SHALL be detected with a third flop.
REQ-017 FSM states: IDLE, CMD, DATA, HOLD.
REQ-018 IDLE -> CMD when synchronized ss_n is low; bit counter cleared.
REQ-019 In CMD, each detected sclk rise SHALL shift synchronized mosi into the index shifter; after CMD_BITS bits the FSM goes to DATA with the counter cleared.
REQ-020 In DATA, each sclk rise SHALL shift mosi into the data shifter; after DATA_W bits the frame is complete and the FSM goes to HOLD.
REQ-021 Completion SHALL occur on the clk cycle after the final bit is sampled; o_wr_strobe or o_err SHALL pulse on that same cycle.
REQ-022 HOLD SHALL ignore further sclk edges and return to IDLE when synchronized ss_n is high, so one frame is accepted per select assertion.
REQ-023 ss_n going high in CMD or DATA SHALL abort: FSM -> IDLE, no register change, no strobe, no err.
REQ-024 Index >= NUM_REGS SHALL pulse o_err and change no register.
REQ-025 Counters SHALL be sized with $clog2 of max(CMD_BITS, DATA_W)+1 and SHALL NOT wrap within a frame.

Reset
REQ-026 reset SHALL force FSM=IDLE, counters and shifters=0, o_wr_strobe=0, o_err=0, o_busy=0 and o_wr_index=0.
REQ-027 reset SHALL load every live and every pending register with RESET_VAL and clear all pending flags.
REQ-028 reset asserted mid-frame SHALL discard the frame; after reset is released, a new frame is accepted only after ss_n has been seen high and then low again.
REQ-029 reset SHALL take priority over i_load, frame completion and abort.

Configuration
REQ-030 Macro SPI_REG_DOUBLE_BUFFER_EN: when defined, a completed frame SHALL write a pending copy of register k and set pending[k]; an i_load pulse SHALL copy every pending register into o_regs on the next clk and clear all pending flags.
REQ-031 With the macro defined, frame completion and i_load on the same cycle SHALL commit the older pending values and leave the new write pending.
REQ-032 When the macro is not defined, a completed frame SHALL update o_regs directly on the completion cycle, i_load SHALL be ignored, and no pending storage SHALL be built.

Verification
REQ-033 Defaults, macro off, frame with index=2 and data=0xA5 -> o_regs[23:16]=0xA5, all other fields 0, o_wr_strobe=1 for one clk, o_wr_index=2.
REQ-034 NUM_REGS=3, frame with index=3 and data=0xFF -> o_err pulses once, o_regs unchanged, no o_wr_strobe.
REQ-035 ss_n raised after 5 of 10 bits -> o_busy falls, no strobe; the next full frame with index=1 and data=0x3C is written correctly.
REQ-036 Macro on: write index=0 data=0x11, then i_load -> o_regs[7:0] stays 0 until 1 clk after i_load, then reads 0x11.
REQ-037 Macro on: i_load coincides with completion of a frame with index=1 data=0x22 -> field 1 unchanged; it reads 0x22 after the next i_load.
REQ-038 reset pulsed mid-frame with RESET_VAL=0x5A -> all fields read 0x5A, o_busy=0, and remaining sclk edges while ss_n stays low cause no write.

Source files
------------

// File: rtl/spi_reg_bank.sv
// SPI-written register bank: a mode-0 frame of CMD_BITS index bits then DATA_W data bits writes one register.
// Optional SPI_REG_DOUBLE_BUFFER_EN stages writes in pending copies committed by i_load.
module spi_reg_bank #(
    parameter int unsigned       NUM_REGS  = 4,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       CMD_BITS  = 2,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_sclk,
    input  logic                         i_mosi,
    input  logic                         i_ss_n,
    input  logic                         i_load,
    output logic [NUM_REGS*DATA_W-1:0]   o_regs,
    output logic                         o_wr_strobe,
    output logic [CMD_BITS-1:0]          o_wr_index,
    output logic                         o_err,
    output logic                         o_busy
);

    localparam int unsigned MAX_BITS = (CMD_BITS > DATA_W) ? CMD_BITS : DATA_W;
    localparam int unsigned CNT_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CMD_BITS-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CMD_BITS-1:0] wr_index_d;
    logic                strobe_d, err_d, wr_en;
    logic                idx_valid;

    logic sclk_s1, sclk_s2, sclk_s3;
    logic mosi_s1, mosi_s2;
    logic ss_s1, ss_s2;
    logic sclk_rise;
    logic armed_q;

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Input synchronizers. ss_n resets to "selected" so that a frame can only
    // start once a genuine high level has propagated and set armed_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_s3 <= 1'b0;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            ss_s1   <= 1'b0;
            ss_s2   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sclk_s1 <= i_sclk;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= i_mosi;
            mosi_s2 <= mosi_s1;
            ss_s1   <= i_ss_n;
            ss_s2   <= ss_s1;
            if (ss_s2) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign idx_valid = (32'(idx_q) < NUM_REGS);

    // Next-state and registered-output logic; abort has priority over a coincident sclk edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        data_d     = data_q;
        wr_index_d = o_wr_index;
        strobe_d   = 1'b0;
        err_d      = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                idx_d  = '0;
                data_d = '0;
                if (!ss_s2 && armed_q) begin
                    state_d = CMD;
                end
            end
            CMD: begin
                if (ss_s2) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    idx_d = CMD_BITS'({idx_q, mosi_s2});
                    if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (ss_s2) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    data_d = DATA_W'({data_q, mosi_s2});
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d      = '0;
                        state_d    = HOLD;
                        wr_index_d = idx_q;
                        if (idx_valid) begin
                            strobe_d = 1'b1;
                            wr_en    = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (ss_s2) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            o_wr_strobe <= 1'b0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_wr_index  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            o_wr_strobe <= strobe_d;
            o_err       <= err_d;
            o_busy      <= (state_d == CMD) || (state_d == DATA);
            o_wr_index  <= wr_index_d;
        end
    end

`ifdef SPI_REG_DOUBLE_BUFFER_EN
    logic [DATA_W-1:0]   pend_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend_flag_q;

    // Commit flagged pending values on i_load; a write in the same cycle stays pending.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else if (i_load) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (pend_flag_q[k]) begin
                    regs_q[k] <= pend_q[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_flag_q <= '0;
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                pend_q[k] <= RESET_VAL;
            end
        end else begin
            if (i_load) begin
                pend_flag_q <= '0;
            end
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_en && (32'(idx_q) == k)) begin
                    pend_q[k]      <= data_d;
                    pend_flag_q[k] <= 1'b1;
                end
            end
        end
    end
`else
    logic load_unused;
    assign load_unused = i_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_en && (32'(idx_q) == k)) begin
                    regs_q[k] <= data_d;
                end
            end
        end
    end
`endif

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign o_regs[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule
